bcd7_scan_ctrl: RTL
===================

Name: bcd7_scan_ctrl

Overview:
- Time-multiplexes NUM_DIGITS packed BCD digits through one shared BCD_to_7_segment decoder.
- The decoder's segment outputs go straight to the pads. This block drives the decoder's 4-bit q input and one active-high digit-enable per display position.
- Provides dead time between digits to stop ghosting, frame-synchronous data update, leading-zero suppression and invalid-code blanking.

Parameters:
- NUM_DIGITS, 4, number of display positions (2..8).
- PRESCALE, 1000, clock cycles each digit is lit (>=1).
- BLANK_CYCLES, 2, dead-time cycles before each digit, all enables off (>=0; 0 skips BLANK).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  scan enable, level.
- load  input  1  one-cycle strobe; captures digits_in into the pending register.
- digits_in  input  4*NUM_DIGITS  packed BCD; digit i is bits [4i+3:4i]; digit 0 is the rightmost position.
- lz_en  input  1  leading-zero suppression enable.
- q  output  4  BCD code to the decoder's q input.
- dig_en  output  NUM_DIGITS  one-hot-or-zero digit enable, active-high.
- frame_done  output  1  one-cycle pulse at the end of each full scan.
- bad_code  output  1  sticky flag, set when a code >9 is scanned.

Behaviour:
- Reset (async assert, sync release): state IDLE, idx=0, timer=0. q=0, dig_en=0, frame_done=0, bad_code=0, pending=0, active=0.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - dig_en=0, q=0.
  - When en=1, the next state is BLANK (or SHOW if BLANK_CYCLES=0), with idx=0 and active<=pending.
- BLANK:
  - Lasts exactly BLANK_CYCLES cycles.
  - dig_en=0; q=active digit idx, so the decoder settles before the enable turns on.
- SHOW:
  - Lasts exactly PRESCALE cycles.
  - q=active digit idx.
  - dig_en[idx]=1 unless digit idx is suppressed; all other dig_en bits are 0.
- End of SHOW:
  - If idx<NUM_DIGITS-1: idx increments, then BLANK.
  - If idx==NUM_DIGITS-1: frame_done=1 for one cycle, idx wraps to 0, active<=pending, then BLANK.
- Frame period: NUM_DIGITS*(BLANK_CYCLES+PRESCALE) cycles.
- Frame latency: first SHOW begins BLANK_CYCLES+1 cycles after en is sampled high.
- en deasserted in any state: next cycle is IDLE, dig_en=0, idx=0, no frame_done. Pending is retained.
- load: pending<=digits_in on any cycle, in any state. active changes only at a frame boundary (the IDLE exit or the wrap), so digits never tear mid-frame.
- load coinciding with a frame boundary: active takes the new digits_in directly (bypass).
- Suppression: a digit is suppressed (dig_en bit stays 0, q still driven) if any of these hold:
  - its code >9;
  - lz_en=1, i>=1, and active digit i and all higher digits are 0.
- Digit 0 is never zero-suppressed.
- bad_code is set in any SHOW cycle where the code is >9. It is cleared only by reset.
- All outputs are registered. dig_en and q change on the same edge.
- Reset mid-scan: immediate return to reset values. Pending is lost.

Decomposition:
- Package bcd7_scan_pkg holds:
  - the state enum (IDLE, BLANK, SHOW);
  - BCD_W=4 and BCD_MAX=9;
  - a function computing the leading-zero suppression mask from the active vector and lz_en.
- Sub-module bcd7_scan_timer: down-counter of width $clog2(max(PRESCALE,BLANK_CYCLES)+1).
  - Loads a count on a start strobe and raises a one-cycle expire pulse.
  - The FSM reuses it for both BLANK and SHOW.

Test Plan (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1):
1. Reset, then load digits_in=16'h1234, lz_en=0, en=1:
   - 1 blank cycle, then dig_en=4'b0001 with q=4 for 4 cycles;
   - then 1 blank, dig_en=4'b0010 with q=3, and so on through digit 3;
   - frame_done pulses once every 20 cycles;
   - dig_en is never multi-hot and is 0 during every blank.
2. Load 16'h0070 with lz_en=1:
   - digits 3 and 2 have dig_en bits 0;
   - digit 1 is lit with q=7, digit 0 is lit with q=0;
   - with lz_en=0, all four digits are lit.
3. Mid-frame load of 16'h5678 while 16'h1234 is displayed:
   - the remaining digits of the current frame still show 1234 values;
   - 5678 appears starting at the next frame's digit 0.
4. Load 16'h00A9:
   - digit 1 (code 10) has dig_en bit 0 while q=4'hA;
   - bad_code rises in that SHOW cycle and stays 1 after reloading valid data.
5. Deassert en during digit 2 SHOW:
   - next cycle dig_en=0 and q=0, no frame_done;
   - on reassert, the scan restarts at digit 0 after 1 blank cycle.
6. Assert rst_n=0 asynchronously mid-SHOW:
   - outputs go to reset values without waiting for a clock edge;
   - after release with en=1, the first lit digit is digit 0 showing q=0, because pending was cleared.

Source files
------------

// File: rtl/bcd7_scan_pkg.sv
// bcd7_scan_pkg: shared types, constants and the leading-zero mask helper for bcd7_scan_ctrl.
package bcd7_scan_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // Bit i set when digit i is a leading zero to hide: it and every higher
    // digit below n are zero. Digit 0 is never masked so a zero value still shows.
    function automatic logic [7:0] lz_mask(input logic [31:0] act, input int n, input logic lz_en);
        logic all_zero;
        lz_mask = '0;
        all_zero = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (i < n) begin
                all_zero = all_zero && (act[BCD_W*i +: BCD_W] == '0);
                lz_mask[i] = lz_en && all_zero;
            end
        end
    endfunction

endpackage

// File: rtl/bcd7_scan_timer.sv
// bcd7_scan_timer: reloadable down-counter with a one-cycle expire pulse.
//   clk, rst_n : clock, async active-low reset
//   start      : load count and begin counting
//   count      : cycles to run minus one
//   expire     : high in the last cycle of the loaded interval
module bcd7_scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] count,
    output logic         expire
);

    logic [W-1:0] cnt;
    logic         busy;

    assign expire = busy && cnt == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            cnt  <= count;
            busy <= 1'b1;
        end else if (expire) begin
            busy <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/bcd7_scan_ctrl.sv
// bcd7_scan_ctrl: multiplexes packed BCD digits through one shared 7-segment decoder.
//   clk, rst_n  : clock, async active-low reset
//   en          : scan enable (level)
//   load        : strobe capturing digits_in into the pending register
//   digits_in   : packed BCD, digit 0 rightmost
//   lz_en       : leading-zero suppression enable
//   q           : BCD code to the decoder
//   dig_en      : one-hot-or-zero digit enables
//   frame_done  : pulse at the end of each full scan
//   bad_code    : sticky flag for a scanned code above 9
module bcd7_scan_ctrl
    import bcd7_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    input  logic                        lz_en,
    output logic [BCD_W-1:0]            q,
    output logic [NUM_DIGITS-1:0]       dig_en,
    output logic                        frame_done,
    output logic                        bad_code
);

    localparam int DW = BCD_W * NUM_DIGITS;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int TW = $clog2((PRESCALE > BLANK_CYCLES ? PRESCALE : BLANK_CYCLES) + 1);
    localparam logic [TW-1:0] SHOW_CNT  = TW'(PRESCALE - 1);
    localparam logic [TW-1:0] FIRST_CNT = BLANK_CYCLES > 0 ? TW'(BLANK_CYCLES - 1) : SHOW_CNT;
    localparam state_t        FIRST     = BLANK_CYCLES > 0 ? BLANK : SHOW;
    localparam logic [IW-1:0] LAST      = IW'(NUM_DIGITS - 1);

    state_t            state, state_n;
    logic [IW-1:0]     idx, idx_n;
    logic [DW-1:0]     pending, active, active_n;
    logic              start, expire, frame, take;
    logic [TW-1:0]     count;
    logic [BCD_W-1:0]  code_n;
    logic [7:0]        zmask;

    bcd7_scan_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .count  (count),
        .expire (expire)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        start   = 1'b0;
        count   = FIRST_CNT;
        frame   = 1'b0;
        take    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_n = FIRST;
                    idx_n   = '0;
                    start   = 1'b1;
                    take    = 1'b1;
                end
            end
            BLANK: begin
                if (!en) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (expire) begin
                    state_n = SHOW;
                    start   = 1'b1;
                    count   = SHOW_CNT;
                end
            end
            SHOW: begin
                if (!en) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (expire) begin
                    state_n = FIRST;
                    start   = 1'b1;
                    frame   = idx == LAST;
                    take    = idx == LAST;
                    idx_n   = idx == LAST ? '0 : idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so a load landing on a frame
    // boundary must reach active (and the decoder) in the same edge.
    assign active_n = take ? (load ? digits_in : pending) : active;
    assign zmask    = lz_mask(32'(active_n), NUM_DIGITS, lz_en);
    assign code_n   = active_n[BCD_W*idx_n +: BCD_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            pending    <= '0;
            active     <= '0;
            q          <= '0;
            dig_en     <= '0;
            frame_done <= 1'b0;
            bad_code   <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            active     <= active_n;
            frame_done <= frame;
            if (load) pending <= digits_in;
            q          <= state_n == IDLE ? '0 : code_n;
            dig_en     <= (state_n == SHOW && code_n <= BCD_MAX && !zmask[idx_n]) ? NUM_DIGITS'(1) << idx_n : '0;
            bad_code   <= bad_code | (state_n == SHOW && code_n > BCD_MAX);
        end
    end

endmodule
